bitonic_seq_ctrl: RTL

//  Time-multiplexed bitonic sorter: one shared compare-exchange unit sorts an N-word register bank in place.

---
 rtl/rths_pkg.sv | 28 ++
 rtl/bitonic_idx_gen.sv | 70 +++++++
 rtl/rths_cmp_swap.sv | 21 ++
 rtl/bitonic_seq_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rths_pkg.sv
// Shared definitions for the RTHS sorter slice: FSM state encodings and
// sizing helpers for the time-multiplexed bitonic controller.
package rths_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Compare-exchange count of a full bitonic network over n words.
    function automatic int unsigned sort_cycles(input int unsigned n);
        int unsigned lg;
        lg = $clog2(n);
        return (n / 2) * lg * (lg + 1) / 2;
    endfunction

    // Bits needed to hold values 0..maxv (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned maxv);
        return (maxv == 0) ? 1 : $clog2(maxv + 1);
    endfunction

    // Bits of the pair counter (N/2 pairs per pass), at least one bit.
    function automatic int unsigned pair_width(input int unsigned n);
        int unsigned lg;
        lg = $clog2(n);
        return (lg > 1) ? lg - 1 : 1;
    endfunction

endpackage

// File: rtl/bitonic_idx_gen.sv
// Bitonic schedule sequencer: walks stage k, sub-stage j and pair p and
// presents the index pair {i, l}, the base direction and the final-step flag.
module bitonic_idx_gen
    import rths_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 step,
    output logic [$clog2(N)-1:0] i_c,
    output logic [$clog2(N)-1:0] l_c,
    output logic                 dir_base_c,
    output logic                 last_c
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned SW   = cnt_width(LOGN);
    localparam int unsigned PW   = pair_width(N);

    logic [SW-1:0]   s_q;    // k = 1 << s_q
    logic [SW-1:0]   jx_q;   // j = 1 << jx_q
    logic [PW-1:0]   p_q;
    logic [LOGN-1:0] pe;
    logic [LOGN-1:0] jbit;
    logic [LOGN-1:0] lowmask;
    logic [LOGN:0]   kbit;
    logic            p_last;

    assign p_last = (p_q == PW'(N / 2 - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= SW'(1);
            jx_q <= '0;
            p_q  <= '0;
        end else if (clr) begin
            s_q  <= SW'(1);
            jx_q <= '0;
            p_q  <= '0;
        end else if (step) begin
            if (!p_last) begin
                p_q <= p_q + PW'(1);
            end else begin
                p_q <= '0;
                if (jx_q != '0) begin
                    jx_q <= jx_q - SW'(1);
                end else begin
                    // next stage starts with j = k/2 of the new k
                    s_q  <= s_q + SW'(1);
                    jx_q <= s_q;
                end
            end
        end
    end

    // i is p with a zero inserted at bit position log2(j)
    always_comb begin
        pe         = LOGN'(p_q);
        jbit       = LOGN'(1) << jx_q;
        lowmask    = jbit - LOGN'(1);
        i_c        = (((pe >> jx_q) << 1) << jx_q) | (pe & lowmask);
        l_c        = i_c | jbit;
        kbit       = (LOGN + 1)'(1) << s_q;
        dir_base_c = (({1'b0, i_c} & kbit) == '0);
        last_c     = (s_q == SW'(LOGN)) && (jx_q == '0) && p_last;
    end

endmodule

// File: rtl/rths_cmp_swap.sv
// Two-input W-bit compare-exchange: x_c/y_c are the words for the low/high
// index; asc=1 puts the minimum on x_c. Equal words never exchange.
module rths_cmp_swap #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         asc,
    output logic [W-1:0] x_c,
    output logic [W-1:0] y_c
);

    logic swap;

    always_comb begin
        swap = asc ? (a > b) : (a < b);
        x_c  = swap ? b : a;
        y_c  = swap ? a : b;
    end

endmodule

// File: rtl/bitonic_seq_ctrl.sv
// Time-multiplexed bitonic sorter: loads N words, sorts in place with one
// compare-exchange per cycle, streams the bank out. RTHS_SWAP_CNT_EN adds swap_cnt.
module bitonic_seq_ctrl
    import rths_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_desc,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done
`ifdef RTHS_SWAP_CNT_EN
    ,
    output logic [cnt_width(sort_cycles(N))-1:0] swap_cnt
`endif
);

    localparam int unsigned LOGN = $clog2(N);

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [W-1:0]    bank [N];
    logic [LOGN-1:0] wr_ptr;
    logic [LOGN-1:0] rd_ptr;
    logic [LOGN-1:0] rd_nxt;
    logic            desc_q;

    logic [LOGN-1:0] cx_i;
    logic [LOGN-1:0] cx_l;
    logic            dir_base;
    logic            sort_last;
    logic [W-1:0]    cx_x;
    logic [W-1:0]    cx_y;

    logic            in_fire;
    logic            out_fire;
    logic            in_last;
    logic            out_last;
    logic            cx_en;

    logic            in_ready_d;
    logic            out_valid_d;
    logic            busy_d;
    logic            done_d;
    logic [W-1:0]    out_data_d;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign in_last  = in_fire && (wr_ptr == LOGN'(N - 1));
    assign out_last = out_fire && (rd_ptr == LOGN'(N - 1));
    assign cx_en    = (state == ST_SORT);
    assign rd_nxt   = rd_ptr + LOGN'(1);

    bitonic_idx_gen #(
        .N          (N)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clr        (!cx_en),
        .step       (cx_en),
        .i_c        (cx_i),
        .l_c        (cx_l),
        .dir_base_c (dir_base),
        .last_c     (sort_last)
    );

    rths_cmp_swap #(
        .W   (W)
    ) u_cmp (
        .a   (bank[cx_i]),
        .b   (bank[cx_l]),
        .asc (dir_base ^ desc_q),
        .x_c (cx_x),
        .y_c (cx_y)
    );

    // Next-state and registered-output values
    always_comb begin
        state_d    = state;
        out_data_d = out_data;
        done_d     = 1'b0;
        case (state)
            ST_LOAD: begin
                if (in_last) state_d = ST_SORT;
            end
            ST_SORT: begin
                if (sort_last) begin
                    state_d    = ST_DRAIN;
                    // the final exchange is written this cycle, so forward it
                    out_data_d = (cx_i == '0) ? cx_x : bank[0];
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (out_last) begin
                        state_d = ST_LOAD;
                        done_d  = 1'b1;
                    end else begin
                        out_data_d = bank[rd_nxt];
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DRAIN);
        busy_d      = (state_d != ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Register bank, pointers and latched sort order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank   <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            desc_q <= 1'b0;
        end else begin
            if (in_fire) begin
                bank[wr_ptr] <= in_data;
                wr_ptr       <= wr_ptr + LOGN'(1);
                if (wr_ptr == '0) desc_q <= cfg_desc;
            end
            if (cx_en) begin
                bank[cx_i] <= cx_x;
                bank[cx_l] <= cx_y;
            end
            if (out_fire) rd_ptr <= rd_nxt;
        end
    end

`ifdef RTHS_SWAP_CNT_EN
    // Equal words never exchange, so a changed low word marks a real swap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_cnt <= '0;
        end else if (in_last) begin
            swap_cnt <= '0;
        end else if (cx_en && (cx_x != bank[cx_i])) begin
            swap_cnt <= swap_cnt + 1'b1;
        end
    end
`endif

endmodule
